// File: rtl/pll_rst_sequencer.sv
// pll_rst_sequencer: qualifies the asynchronous PLL lock in the ADC clock domain
// and produces a synchronously released active-low datapath reset. It also keeps
// lock/loss-of-lock telemetry for the housekeeping registers.
`timescale 1ns/1ps
module pll_rst_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_QUAL   = 4096,
  parameter int RST_HOLD    = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pll_locked_i,
  input  logic             sw_rst_i,
  input  logic             loss_clr_i,
  output logic             rstn_o,
  output logic             locked_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic             loss_sticky_o
);

  localparam int QW = $clog2(LOCK_QUAL + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [QW-1:0]    Q_LAST  = QW'(LOCK_QUAL - 1);
  localparam logic [HW-1:0]    H_LAST  = HW'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_QUAL = 2'd1,
    ST_REL  = 2'd2,
    ST_RUN  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  state_t                 state, state_nx;
  logic [QW-1:0]          q, q_nx;
  logic [HW-1:0]          h, h_nx;
  logic                   loss_evt;

  assign lock_s   = sync[SYNC_STAGES-1];
  assign state_o  = state;
  assign loss_evt = (state == ST_RUN) && !lock_s;

  // Bring the asynchronous lock indication into the ADC clock domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], pll_locked_i};
  end

  // State register, qualification/hold counters and registered reset/lock outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_WAIT;
      q        <= '0;
      h        <= '0;
      rstn_o   <= 1'b0;
      locked_o <= 1'b0;
    end else begin
      state    <= state_nx;
      q        <= q_nx;
      h        <= h_nx;
      rstn_o   <= (state_nx == ST_RUN);
      locked_o <= (state_nx == ST_RUN);
    end
  end

  // Next-state logic: a lock drop always wins, software reset only acts in RUN.
  always_comb begin
    state_nx = state;
    q_nx     = q;
    h_nx     = h;
    case (state)
      ST_WAIT: begin
        q_nx = '0;
        if (lock_s) begin
          if (LOCK_QUAL == 1) begin
            state_nx = ST_REL;
            h_nx     = '0;
          end else begin
            state_nx = ST_QUAL;
            q_nx     = QW'(1);
          end
        end
      end
      ST_QUAL: begin
        if (!lock_s) begin
          state_nx = ST_WAIT;
          q_nx     = '0;
        end else if (q == Q_LAST) begin
          state_nx = ST_REL;
          h_nx     = '0;
        end else begin
          q_nx = q + 1'b1;
        end
      end
      ST_REL: begin
        if (!lock_s) begin
          state_nx = ST_WAIT;
        end else if (h == H_LAST) begin
          state_nx = ST_RUN;
        end else begin
          h_nx = h + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nx = ST_WAIT;
        end else if (sw_rst_i) begin
          state_nx = ST_REL;
          h_nx     = '0;
        end
      end
      default: state_nx = ST_WAIT;
    endcase
  end

  // Loss-of-lock telemetry: a coincident clear never swallows a new loss event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      loss_cnt_o    <= '0;
      loss_sticky_o <= 1'b0;
    end else if (loss_evt) begin
      loss_sticky_o <= 1'b1;
      if (loss_clr_i)                 loss_cnt_o <= CNT_W'(1);
      else if (loss_cnt_o != CNT_MAX) loss_cnt_o <= loss_cnt_o + 1'b1;
    end else if (loss_clr_i) begin
      loss_cnt_o    <= '0;
      loss_sticky_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// tb_pll_rst_sequencer: directed bench for pll_rst_sequencer with an
// expected-value queue filled as each step is driven and drained after the edge.
`timescale 1ns/1ps
module tb_pll_rst_sequencer;

  localparam int SYNC     = 2;
  localparam int LQ       = 8;
  localparam int RH       = 4;
  localparam int CW       = 2;
  localparam int REL_EDGE = SYNC + LQ - 1;
  localparam int RUN_EDGE = SYNC + LQ + RH - 1;

  typedef struct packed {
    logic       rstn;
    logic       locked;
    logic [1:0] st;
    logic [1:0] cnt;
    logic       sticky;
  } exp_t;

  logic          clk;
  logic          rstn;
  logic          pll_locked_i;
  logic          sw_rst_i;
  logic          loss_clr_i;
  logic          rstn_o;
  logic          locked_o;
  logic [1:0]    state_o;
  logic [CW-1:0] loss_cnt_o;
  logic          loss_sticky_o;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors    = 0;
  int    miscompares = 0;
  logic [1:0] cnt_e    = '0;
  logic       sticky_e = 1'b0;

  pll_rst_sequencer #(
    .SYNC_STAGES(SYNC),
    .LOCK_QUAL  (LQ),
    .RST_HOLD   (RH),
    .CNT_W      (CW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pll_locked_i (pll_locked_i),
    .sw_rst_i     (sw_rst_i),
    .loss_clr_i   (loss_clr_i),
    .rstn_o       (rstn_o),
    .locked_o     (locked_o),
    .state_o      (state_o),
    .loss_cnt_o   (loss_cnt_o),
    .loss_sticky_o(loss_sticky_o)
  );

  // Free-running ADC clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] st);
    exp_t e;
    e.rstn   = (st == 2'd3);
    e.locked = (st == 2'd3);
    e.st     = st;
    e.cnt    = cnt_e;
    e.sticky = sticky_e;
    return e;
  endfunction

  function automatic logic [1:0] st_of(input int k);
    if (k < SYNC)     return 2'd0;
    if (k < REL_EDGE) return 2'd1;
    if (k < RUN_EDGE) return 2'd2;
    return 2'd3;
  endfunction

  task automatic compare();
    string t;
    exp_t  e;
    exp_t  o;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    o = {rstn_o, locked_o, state_o, loss_cnt_o, loss_sticky_o};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed {rstn,locked,st,cnt,sticky}=%b required %b", t, o, e);
    end
  endtask

  task automatic tick(input string tag, input exp_t e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic check_now(input string tag, input exp_t e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
    compare();
  endtask

  task automatic walk(input int k0, input string name);
    pll_locked_i = 1'b1;
    for (int k = k0; k <= RUN_EDGE; k++)
      tick($sformatf("%s edge%0d", name, k), mk(st_of(k)));
  endtask

  task automatic async_reset(input string name);
    rstn = 1'b0;
    #2;
    cnt_e    = '0;
    sticky_e = 1'b0;
    check_now(name, mk(2'd0));
    rstn = 1'b1;
  endtask

  task automatic lose(input logic sw, input logic clr, input string name);
    pll_locked_i = 1'b0;
    tick({name, " drop0"}, mk(2'd3));
    tick({name, " drop1"}, mk(2'd3));
    sw_rst_i   = sw;
    loss_clr_i = clr;
    if (clr)              cnt_e = 2'd1;
    else if (cnt_e != 2'd3) cnt_e = cnt_e + 2'd1;
    sticky_e = 1'b1;
    tick({name, " loss"}, mk(2'd0));
    sw_rst_i   = 1'b0;
    loss_clr_i = 1'b0;
  endtask

  // Directed sequence of scenarios.
  initial begin
    rstn         = 1'b0;
    pll_locked_i = 1'b1;
    sw_rst_i     = 1'b0;
    loss_clr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("power-up reset", mk(2'd0));
    rstn = 1'b1;
    walk(0, "power-up");

    sw_rst_i = 1'b1;
    tick("sw_rst hold0", mk(2'd2));
    sw_rst_i = 1'b0;
    for (int i = 1; i < RH; i++) tick($sformatf("sw_rst hold%0d", i), mk(2'd2));
    tick("sw_rst release", mk(2'd3));

    sw_rst_i = 1'b1;
    tick("mid-REL h0", mk(2'd2));
    sw_rst_i = 1'b0;
    tick("mid-REL h1", mk(2'd2));
    async_reset("async reset mid-REL");
    walk(0, "post-async");

    async_reset("reset before glitch");
    for (int k = 0; k < 5; k++) begin
      sw_rst_i = (k == 3);
      tick($sformatf("glitch edge%0d", k), mk(st_of(k)));
    end
    sw_rst_i = 1'b0;
    pll_locked_i = 1'b0;
    tick("glitch low", mk(2'd1));
    pll_locked_i = 1'b1;
    tick("glitch rise", mk(2'd1));
    tick("glitch back to WAIT", mk(2'd0));
    walk(2, "requal");

    for (int i = 0; i < 4; i++) begin
      lose(1'b0, 1'b0, $sformatf("loss%0d", i));
      walk(0, $sformatf("relock%0d", i));
    end

    lose(1'b0, 1'b1, "clr+loss");
    walk(0, "relock clr");
    loss_clr_i = 1'b1;
    cnt_e      = '0;
    sticky_e   = 1'b0;
    tick("plain clear", mk(2'd3));
    loss_clr_i = 1'b0;

    lose(1'b1, 1'b0, "sw+loss");
    tick("sw+loss stays WAIT", mk(2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
